axi4_stream_pkt_arbiter: RTL and testbench

- Packet-level round-robin arbiter that merges INPUTS_AMOUNT AXI4-Stream sources onto one master stream.
- Each source is the output side of an axi4_stream_fifo in SMART mode.
- An input is eligible only when its FIFO reports at least one complete packet (pkts_amount > 0).
- Once granted, the input owns the output until its tlast handshake, so packets are never interleaved.

---
 rtl/axi4_stream_arb_pkg.sv | 19 +
 rtl/axi4_stream_if.sv | 20 ++
 rtl/rr_select.sv | 30 +++
 rtl/axi4_stream_pkt_arbiter.sv | 110 +++++++++++
 tb/tb_axi4_stream_pkt_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_arb_pkg.sv
// Shared types and helpers for the AXI4-Stream arbiter family.
package axi4_stream_arb_pkg;

    typedef enum logic [0:0] { IDLE_S, PASS_S } arb_state_t;

    localparam int FLAT_MAX_W = 256;

    // Extracts field idx (fw bits wide) from a flattened per-source count vector.
    function automatic logic [31:0] pkts_field(
        input logic [FLAT_MAX_W-1:0] flat,
        input int                    idx,
        input int                    fw
    );
        logic [FLAT_MAX_W-1:0] shifted;
        shifted = flat >> (idx * fw);
        return 32'(shifted) & ((32'd1 << fw) - 32'd1);
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH-1:0]     tdata;
    logic [TDATA_WIDTH/8-1:0]   tstrb;
    logic [TDATA_WIDTH/8-1:0]   tkeep;
    logic                       tlast;
    logic [TUSER_WIDTH-1:0]     tuser;
    logic [TDEST_WIDTH-1:0]     tdest;
    logic [TID_WIDTH-1:0]       tid;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid, input tready);
    modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid, output tready);
endinterface

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping modulo N.
module rr_select #(
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] next,
    output logic             any_req
);
    int dist_s;
    int best_dist_s;

    // Smallest rotational distance from last+1 wins; works for non-power-of-2 N.
    always_comb begin
        next        = last;
        best_dist_s = N;
        dist_s      = 0;
        for (int j = 0; j < N; j++) begin
            dist_s = (j + N - 1 - int'(last)) % N;
            if (req[j] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                next        = SEL_W'(j);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        any_req = |req;
    end
endmodule

// File: rtl/axi4_stream_pkt_arbiter.sv
// Packet-level round-robin arbiter merging INPUTS_AMOUNT AXI4-Stream sources onto one stream.
// A source is eligible only with a complete packet queued and owns the output until its tlast.
module axi4_stream_pkt_arbiter
    import axi4_stream_arb_pkg::*;
#(
    parameter int TDATA_WIDTH   = 32,
    parameter int TUSER_WIDTH   = 1,
    parameter int TDEST_WIDTH   = 1,
    parameter int TID_WIDTH     = 1,
    parameter int INPUTS_AMOUNT = 4,
    parameter int ADDR_WIDTH    = 3,
    parameter int SEL_WIDTH     = (INPUTS_AMOUNT > 1) ? $clog2(INPUTS_AMOUNT) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [INPUTS_AMOUNT*(ADDR_WIDTH+1)-1:0] pkts_amount_i,
    axi4_stream_if.slave                            pkt_i [INPUTS_AMOUNT-1:0],
    axi4_stream_if.master                           pkt_o,
    output logic [SEL_WIDTH-1:0]                    grant_o,
    output logic                                    busy_o,
    output logic [31:0]                             pkts_sent_o
);
    localparam int STRB_WIDTH = TDATA_WIDTH / 8;

    arb_state_t               state_r;
    logic [INPUTS_AMOUNT-1:0] req_s;
    logic [INPUTS_AMOUNT-1:0] src_tvalid_s;
    logic [INPUTS_AMOUNT-1:0] src_tlast_s;
    logic [TDATA_WIDTH-1:0]   src_tdata_s [INPUTS_AMOUNT];
    logic [STRB_WIDTH-1:0]    src_tstrb_s [INPUTS_AMOUNT];
    logic [STRB_WIDTH-1:0]    src_tkeep_s [INPUTS_AMOUNT];
    logic [TUSER_WIDTH-1:0]   src_tuser_s [INPUTS_AMOUNT];
    logic [TDEST_WIDTH-1:0]   src_tdest_s [INPUTS_AMOUNT];
    logic [TID_WIDTH-1:0]     src_tid_s   [INPUTS_AMOUNT];
    logic [SEL_WIDTH-1:0]     next_grant_s;
    logic                     any_req_s;
    logic                     pass_s;
    logic                     eop_s;

    // Interface arrays only allow constant indices, so flatten each source into plain arrays.
    for (genvar i = 0; i < INPUTS_AMOUNT; i++) begin : g_src
        assign req_s[i]        = pkts_field(FLAT_MAX_W'(pkts_amount_i), i, ADDR_WIDTH + 1) != 32'd0;
        assign src_tvalid_s[i] = pkt_i[i].tvalid;
        assign src_tlast_s[i]  = pkt_i[i].tlast;
        assign src_tdata_s[i]  = pkt_i[i].tdata;
        assign src_tstrb_s[i]  = pkt_i[i].tstrb;
        assign src_tkeep_s[i]  = pkt_i[i].tkeep;
        assign src_tuser_s[i]  = pkt_i[i].tuser;
        assign src_tdest_s[i]  = pkt_i[i].tdest;
        assign src_tid_s[i]    = pkt_i[i].tid;
        assign pkt_i[i].tready = pass_s && (grant_o == SEL_WIDTH'(i)) && pkt_o.tready;
    end

    rr_select #(
        .N     (INPUTS_AMOUNT),
        .SEL_W (SEL_WIDTH)
    ) u_rr_select (
        .req     (req_s),
        .last    (grant_o),
        .next    (next_grant_s),
        .any_req (any_req_s)
    );

    assign pass_s = (state_r == PASS_S);
    assign eop_s  = pass_s && src_tvalid_s[grant_o] && pkt_o.tready && src_tlast_s[grant_o];

    // Zero-latency passthrough from the granted source; tvalid gated outside PASS.
    always_comb begin
        pkt_o.tvalid = pass_s && src_tvalid_s[grant_o];
        pkt_o.tdata  = src_tdata_s[grant_o];
        pkt_o.tstrb  = src_tstrb_s[grant_o];
        pkt_o.tkeep  = src_tkeep_s[grant_o];
        pkt_o.tlast  = src_tlast_s[grant_o];
        pkt_o.tuser  = src_tuser_s[grant_o];
        pkt_o.tdest  = src_tdest_s[grant_o];
        pkt_o.tid    = src_tid_s[grant_o];
    end

    // Arbitration FSM with grant, busy flag and completed-packet counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE_S;
            grant_o     <= SEL_WIDTH'(INPUTS_AMOUNT - 1);
            busy_o      <= 1'b0;
            pkts_sent_o <= 32'd0;
        end else begin
            case (state_r)
                IDLE_S: begin
                    if (any_req_s) begin
                        grant_o <= next_grant_s;
                        state_r <= PASS_S;
                        busy_o  <= 1'b1;
                    end
                end
                PASS_S: begin
                    // Always return to IDLE: source counts lag the tlast read by a cycle.
                    if (eop_s) begin
                        state_r     <= IDLE_S;
                        busy_o      <= 1'b0;
                        pkts_sent_o <= pkts_sent_o + 32'd1;
                    end
                end
                default: begin
                    state_r <= IDLE_S;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Self-checking bench: FIFO-like source models, an output scoreboard, and a 3-input rotation instance.
module tb_axi4_stream_pkt_arbiter;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 4-input instance
    axi4_stream_if #(.TDATA_WIDTH(32)) src4 [3:0] ();
    axi4_stream_if #(.TDATA_WIDTH(32)) out4 ();
    logic [4*CW-1:0] pkts4;
    logic [1:0]      grant4;
    logic            busy4;
    logic [31:0]     sent4;
    logic            out4_tready;

    axi4_stream_pkt_arbiter #(.INPUTS_AMOUNT(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .pkts_amount_i(pkts4),
        .pkt_i(src4), .pkt_o(out4),
        .grant_o(grant4), .busy_o(busy4), .pkts_sent_o(sent4)
    );

    // 3-input instance: every source always offers single-word packets when enabled
    axi4_stream_if #(.TDATA_WIDTH(32)) src3 [2:0] ();
    axi4_stream_if #(.TDATA_WIDTH(32)) out3 ();
    logic [3*CW-1:0] pkts3;
    logic [1:0]      grant3;
    logic            busy3;
    logic [31:0]     sent3;
    logic            en3 = 1'b0;

    axi4_stream_pkt_arbiter #(.INPUTS_AMOUNT(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .pkts_amount_i(pkts3),
        .pkt_i(src3), .pkt_o(out3),
        .grant_o(grant3), .busy_o(busy3), .pkts_sent_o(sent3)
    );

    assign pkts3      = en3 ? {3{4'd1}} : 12'd0;
    assign out3.tready = 1'b1;
    for (genvar i = 0; i < 3; i++) begin : g_src3
        assign src3[i].tvalid = 1'b1;
        assign src3[i].tdata  = 32'(i);
        assign src3[i].tstrb  = 4'hF;
        assign src3[i].tkeep  = 4'hF;
        assign src3[i].tlast  = 1'b1;
        assign src3[i].tuser  = 1'b0;
        assign src3[i].tdest  = 1'b0;
        assign src3[i].tid    = 1'b0;
    end

    // Source models for the 4-input instance
    logic [31:0] mem      [4][64];
    logic        mem_last [4][64];
    logic [5:0]  rd_ptr [4];
    logic [5:0]  wr_ptr [4];
    int          pushed [4];
    int          popped [4];
    logic [3:0]  gate;
    logic [3:0]  s_valid, s_tready, s_last;
    logic [31:0] s_data [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s_valid[i]          = (rd_ptr[i] != wr_ptr[i]) && gate[i];
            s_data[i]           = mem[i][rd_ptr[i]];
            s_last[i]           = mem_last[i][rd_ptr[i]];
            pkts4[i*CW +: CW]   = CW'(pushed[i] - popped[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                rd_ptr[i] <= wr_ptr[i];
                popped[i] <= pushed[i];
            end else if (s_valid[i] && s_tready[i]) begin
                rd_ptr[i] <= rd_ptr[i] + 6'd1;
                if (s_last[i]) popped[i] <= popped[i] + 1;
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_src4
        assign src4[i].tvalid = s_valid[i];
        assign src4[i].tdata  = s_data[i];
        assign src4[i].tstrb  = 4'hF;
        assign src4[i].tkeep  = 4'hF;
        assign src4[i].tlast  = s_last[i];
        assign src4[i].tuser  = 1'b0;
        assign src4[i].tdest  = 1'b0;
        assign src4[i].tid    = 1'b0;
        assign s_tready[i]    = src4[i].tready;
    end
    assign out4.tready = out4_tready;

    // Scoreboard of expected output beats, in expected grant order
    typedef struct {
        int          src;
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t sb[$];

    always @(negedge clk) begin
        beat_t e;
        if (!rst && out4.tvalid && out4_tready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got src=%0d data=%h with nothing expected", grant4, out4.tdata);
            end else begin
                e = sb.pop_front();
                if (out4.tdata !== e.data || out4.tlast !== e.last || grant4 !== 2'(e.src)) begin
                    errors++;
                    $display("FAIL beat: got src=%0d data=%h last=%b, expected src=%0d data=%h last=%b",
                             grant4, out4.tdata, out4.tlast, e.src, e.data, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_pkt(input int s, input int len, input logic [31:0] base, input bit expect_it);
        for (int b = 0; b < len; b++) begin
            mem[s][wr_ptr[s] + 6'(b)]      = base + 32'(b);
            mem_last[s][wr_ptr[s] + 6'(b)] = (b == len - 1);
            if (expect_it) sb.push_back('{s, base + 32'(b), (b == len - 1)});
        end
        wr_ptr[s] = wr_ptr[s] + 6'(len);
        pushed[s] = pushed[s] + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_idle(input int target, input int budget);
        int c;
        c = 0;
        while (!(sent4 == 32'(target) && busy4 == 1'b0 && sb.size() == 0) && c < budget) begin
            tick();
            c++;
        end
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL drain_timeout: sent=%0d pending=%0d, expected sent=%0d pending=0", sent4, sb.size(), target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 5;
        if (grant4 !== 2'd3)      begin errors++; $display("FAIL reset_grant: got %0d expected 3", grant4); end
        if (busy4 !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy4); end
        if (sent4 !== 32'd0)      begin errors++; $display("FAIL reset_sent: got %0d expected 0", sent4); end
        if (out4.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", out4.tvalid); end
        if (s_tready !== 4'b0)    begin errors++; $display("FAIL reset_tready: got %b expected 0000", s_tready); end
        rst = 1'b0;
    endtask

    task automatic test_single_src();
        int pass_cycles;
        gen_pkt(2, 3, 32'h0000_2000, 1'b1);
        checks++;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL single_bubble: busy got %b expected 0", busy4); end
        tick();
        checks += 2;
        if (grant4 !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", grant4); end
        if (busy4 !== 1'b1)  begin errors++; $display("FAIL single_busy: got %b expected 1", busy4); end
        pass_cycles = 0;
        for (int c = 0; c < 20 && busy4; c++) begin
            pass_cycles++;
            tick();
        end
        checks += 3;
        if (pass_cycles !== 3) begin errors++; $display("FAIL single_pass_len: got %0d expected 3", pass_cycles); end
        if (sent4 !== 32'd1)   begin errors++; $display("FAIL single_sent: got %0d expected 1", sent4); end
        if (sb.size() !== 0)   begin errors++; $display("FAIL single_drain: pending %0d expected 0", sb.size()); end
    endtask

    task automatic test_round_robin();
        int idle_cycles;
        bit seen;
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 4; s++)
                gen_pkt(s, 2, 32'(s * 256 + p * 16), 1'b1);
        idle_cycles = 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !(sent4 == 32'd8 && busy4 == 1'b0); c++) begin
            if (busy4) seen = 1'b1;
            else if (seen) idle_cycles++;
            tick();
        end
        checks += 3;
        if (sent4 !== 32'd8)   begin errors++; $display("FAIL rr_sent: got %0d expected 8", sent4); end
        if (idle_cycles !== 7) begin errors++; $display("FAIL rr_bubbles: got %0d expected 7", idle_cycles); end
        if (sb.size() !== 0)   begin errors++; $display("FAIL rr_drain: pending %0d expected 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        gen_pkt(1, 4, 32'h0000_B100, 1'b1);
        gen_pkt(3, 2, 32'h0000_B300, 1'b1);
        tick();
        for (int c = 0; c < 12 && sent4 == 32'd0; c++) begin
            out4_tready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
            #1;
            checks += 3;
            if (grant4 !== 2'd1)          begin errors++; $display("FAIL bp_grant: got %0d expected 1", grant4); end
            if (s_tready[3] !== 1'b0)     begin errors++; $display("FAIL bp_tready3: got %b expected 0", s_tready[3]); end
            if (s_tready[1] !== out4_tready) begin errors++; $display("FAIL bp_tready1: got %b expected %b", s_tready[1], out4_tready); end
            tick();
        end
        out4_tready = 1'b1;
        wait_idle(2, 40);
    endtask

    task automatic test_fairness();
        do_reset();
        gen_pkt(0, 1, 32'h0000_F000, 1'b1);
        gen_pkt(2, 1, 32'h0000_F200, 1'b1);
        gen_pkt(0, 1, 32'h0000_F001, 1'b1);
        gen_pkt(0, 1, 32'h0000_F002, 1'b1);
        wait_idle(4, 40);
    endtask

    task automatic test_tvalid_gap();
        do_reset();
        gen_pkt(0, 3, 32'h0000_C000, 1'b1);
        tick();
        tick();
        gate[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks += 3;
            if (out4.tvalid !== 1'b0) begin errors++; $display("FAIL gap_tvalid: got %b expected 0", out4.tvalid); end
            if (busy4 !== 1'b1)       begin errors++; $display("FAIL gap_busy: got %b expected 1", busy4); end
            if (grant4 !== 2'd0)      begin errors++; $display("FAIL gap_grant: got %0d expected 0", grant4); end
            tick();
        end
        gate[0] = 1'b1;
        wait_idle(1, 20);
    endtask

    task automatic test_reset_midpacket();
        gen_pkt(1, 5, 32'h0000_D000, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks += 5;
        if (busy4 !== 1'b0)       begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy4); end
        if (grant4 !== 2'd3)      begin errors++; $display("FAIL mid_rst_grant: got %0d expected 3", grant4); end
        if (sent4 !== 32'd0)      begin errors++; $display("FAIL mid_rst_sent: got %0d expected 0", sent4); end
        if (s_tready !== 4'b0)    begin errors++; $display("FAIL mid_rst_tready: got %b expected 0000", s_tready); end
        if (out4.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b expected 0", out4.tvalid); end
        rst = 1'b0;
        sb.delete();
        tick();
        tick();
        checks++;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL mid_rst_idle: busy got %b expected 0", busy4); end
    endtask

    task automatic test_rotation3();
        int n;
        logic prev;
        do_reset();
        en3 = 1'b1;
        n = 0;
        prev = 1'b0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            checks++;
            if (grant3 > 2'd2) begin errors++; $display("FAIL rot3_range: got %0d expected below 3", grant3); end
            if (busy3 && !prev) begin
                checks++;
                if (grant3 !== 2'(n % 3)) begin errors++; $display("FAIL rot3_order: got %0d expected %0d", grant3, n % 3); end
                n++;
            end
            prev = busy3;
            tick();
        end
        en3 = 1'b0;
        checks++;
        if (n !== 6) begin errors++; $display("FAIL rot3_count: got %0d grants expected 6", n); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            wr_ptr[i] = 6'd0;
            pushed[i] = 0;
            for (int j = 0; j < 64; j++) begin
                mem[i][j]      = 32'd0;
                mem_last[i][j] = 1'b0;
            end
        end
        gate        = 4'hF;
        out4_tready = 1'b1;

        test_reset();
        test_single_src();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_tvalid_gap();
        test_reset_midpacket();
        test_rotation3();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
